// File: rtl/core_pkg.sv
// Shared definitions for the ARMv8 pipeline control blocks.
package core_pkg;

  localparam logic [4:0] XZR = 5'd31;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    LU_STALL = 1'b1
  } hz_state_e;

endpackage

// File: rtl/perf_counter.sv
// Wrapping event counter; a clear wins over an increment in the same cycle.
module perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/id_hazard_ctrl.sv
// ID-stage sequencing: load-use stalls, MEM-stage branch flushes and
// data-memory freezes, with stall/freeze/flush event counters.
module id_hazard_ctrl
  import core_pkg::*;
#(
  parameter int LOAD_STALL = 1,
  parameter int CNT_W      = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       if_id_rn,
  input  logic [4:0]       if_id_rm,
  input  logic             uses_rn,
  input  logic             uses_rm,
  input  logic             id_ex_memread,
  input  logic [4:0]       id_ex_rd,
  input  logic             branch_taken,
  input  logic             mem_busy,
  input  logic             cnt_clear,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             ex_mem_flush,
  output logic             pipe_freeze,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] freeze_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [2:0] STALL_EXTRA = 3'(LOAD_STALL - 1);

  hz_state_e  state_q, state_d;
  logic [2:0] rem_q, rem_d;
  logic       hazard;
  logic       inc_stall, inc_freeze, inc_flush;

  assign hazard = id_ex_memread && (id_ex_rd != XZR) &&
                  ((uses_rn && (if_id_rn == id_ex_rd)) ||
                   (uses_rm && (if_id_rm == id_ex_rd)));

  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    ex_mem_flush = 1'b0;
    pipe_freeze  = 1'b0;
    state_d      = state_q;
    rem_d        = rem_q;
    inc_stall    = 1'b0;
    inc_freeze   = 1'b0;
    inc_flush    = 1'b0;

    // Reset drives the outputs directly so they respond before any clock edge.
    if (!reset) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
    end else if (mem_busy) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      pipe_freeze = 1'b1;
      inc_freeze  = 1'b1;
    end else if (branch_taken) begin
      if_id_write  = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      ex_mem_flush = 1'b1;
      state_d      = RUN;
      rem_d        = '0;
      inc_flush    = 1'b1;
    end else if (state_q == LU_STALL) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
      inc_stall    = 1'b1;
      if (rem_q <= 3'd1) begin
        state_d = RUN;
        rem_d   = '0;
      end else begin
        rem_d = rem_q - 3'd1;
      end
    end else if (hazard) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
      inc_stall    = 1'b1;
      if (LOAD_STALL > 1) begin
        state_d = LU_STALL;
        rem_d   = STALL_EXTRA;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i  (clock),
    .rst_ni (reset),
    .inc_i  (inc_stall),
    .clr_i  (cnt_clear),
    .cnt_o  (stall_cnt)
  );

  perf_counter #(.CNT_W(CNT_W)) u_freeze_cnt (
    .clk_i  (clock),
    .rst_ni (reset),
    .inc_i  (inc_freeze),
    .clr_i  (cnt_clear),
    .cnt_o  (freeze_cnt)
  );

  perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk_i  (clock),
    .rst_ni (reset),
    .inc_i  (inc_flush),
    .clr_i  (cnt_clear),
    .cnt_o  (flush_cnt)
  );

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Scoreboard bench for id_hazard_ctrl: two instances (LOAD_STALL 1 and 3)
// share stimulus; a reference model queues expectations, a monitor checks.
module tb_id_hazard_ctrl;

  localparam int CW = 32;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [4:0] if_id_rn = '0, if_id_rm = '0, id_ex_rd = '0;
  logic       uses_rn = 1'b0, uses_rm = 1'b0, id_ex_memread = 1'b0;
  logic       branch_taken = 1'b0, mem_busy = 1'b0, cnt_clear = 1'b0;

  logic          pcw_a, ifw_a, iff_a, bub_a, exf_a, frz_a;
  logic [CW-1:0] sc_a, zc_a, fc_a;
  logic          pcw_b, ifw_b, iff_b, bub_b, exf_b, frz_b;
  logic [CW-1:0] sc_b, zc_b, fc_b;

  always #5 clock = ~clock;

  id_hazard_ctrl #(.LOAD_STALL(1), .CNT_W(CW)) dut_a (
    .clock(clock), .reset(reset), .if_id_rn(if_id_rn), .if_id_rm(if_id_rm),
    .uses_rn(uses_rn), .uses_rm(uses_rm), .id_ex_memread(id_ex_memread),
    .id_ex_rd(id_ex_rd), .branch_taken(branch_taken), .mem_busy(mem_busy),
    .cnt_clear(cnt_clear), .pc_write(pcw_a), .if_id_write(ifw_a),
    .if_id_flush(iff_a), .id_ex_bubble(bub_a), .ex_mem_flush(exf_a),
    .pipe_freeze(frz_a), .stall_cnt(sc_a), .freeze_cnt(zc_a), .flush_cnt(fc_a)
  );

  id_hazard_ctrl #(.LOAD_STALL(3), .CNT_W(CW)) dut_b (
    .clock(clock), .reset(reset), .if_id_rn(if_id_rn), .if_id_rm(if_id_rm),
    .uses_rn(uses_rn), .uses_rm(uses_rm), .id_ex_memread(id_ex_memread),
    .id_ex_rd(id_ex_rd), .branch_taken(branch_taken), .mem_busy(mem_busy),
    .cnt_clear(cnt_clear), .pc_write(pcw_b), .if_id_write(ifw_b),
    .if_id_flush(iff_b), .id_ex_bubble(bub_b), .ex_mem_flush(exf_b),
    .pipe_freeze(frz_b), .stall_cnt(sc_b), .freeze_cnt(zc_b), .flush_cnt(fc_b)
  );

  // ctl = {pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_flush, pipe_freeze}
  typedef struct packed {
    logic [5:0]    ctl;
    logic [5:0]    mask;
    logic [CW-1:0] sc;
    logic [CW-1:0] zc;
    logic [CW-1:0] fc;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  int checks = 0;
  int errors = 0;

  // Reference model: owed = stall cycles still owed after this one.
  int          ls[2] = '{1, 3};
  int          owed[2] = '{0, 0};
  int unsigned m_sc[2] = '{0, 0};
  int unsigned m_zc[2] = '{0, 0};
  int unsigned m_fc[2] = '{0, 0};

  task automatic model_step(input int d, output exp_t e);
    bit haz;
    haz = id_ex_memread && (id_ex_rd != 5'd31) &&
          ((uses_rn && if_id_rn == id_ex_rd) || (uses_rm && if_id_rm == id_ex_rd));
    if (!reset) begin
      owed[d] = 0; m_sc[d] = 0; m_zc[d] = 0; m_fc[d] = 0;
    end
    e.sc   = m_sc[d];
    e.zc   = m_zc[d];
    e.fc   = m_fc[d];
    e.mask = 6'b111111;
    if (!reset) begin
      e.ctl = 6'b000100;
    end else if (mem_busy) begin
      e.ctl = 6'b000001;
      m_zc[d]++;
    end else if (branch_taken) begin
      e.ctl  = 6'b101110;
      e.mask = 6'b101111;  // IF/ID is being flushed, its write enable is moot
      owed[d] = 0;
      m_fc[d]++;
    end else if (owed[d] > 0) begin
      e.ctl = 6'b000100;
      owed[d]--;
      m_sc[d]++;
    end else if (haz) begin
      e.ctl = 6'b000100;
      owed[d] = ls[d] - 1;
      m_sc[d]++;
    end else begin
      e.ctl = 6'b110000;
    end
    if (reset && cnt_clear) begin
      m_sc[d] = 0; m_zc[d] = 0; m_fc[d] = 0;
    end
  endtask

  task automatic drive(input logic r, input logic mr, input logic [4:0] rd,
                       input logic [4:0] rn, input logic [4:0] rm,
                       input logic urn, input logic urm, input logic br,
                       input logic busy, input logic clr);
    exp_t ea, eb;
    @(posedge clock);
    #1;
    reset = r; id_ex_memread = mr; id_ex_rd = rd; if_id_rn = rn; if_id_rm = rm;
    uses_rn = urn; uses_rm = urm; branch_taken = br; mem_busy = busy; cnt_clear = clr;
    model_step(0, ea);
    model_step(1, eb);
    q_a.push_back(ea);
    q_b.push_back(eb);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic chk(input string nm, input logic [CW-1:0] act, input logic [CW-1:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s @%0t actual=%0h expected=%0h", nm, $time, act, exp_v);
    end
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (q_a.size() > 0) begin
      e = q_a.pop_front();
      chk("ctl_ls1", CW'({pcw_a, ifw_a, iff_a, bub_a, exf_a, frz_a} & e.mask), CW'(e.ctl & e.mask));
      chk("stall_cnt_ls1", sc_a, e.sc);
      chk("freeze_cnt_ls1", zc_a, e.zc);
      chk("flush_cnt_ls1", fc_a, e.fc);
    end
    if (q_b.size() > 0) begin
      e = q_b.pop_front();
      chk("ctl_ls3", CW'({pcw_b, ifw_b, iff_b, bub_b, exf_b, frz_b} & e.mask), CW'(e.ctl & e.mask));
      chk("stall_cnt_ls3", sc_b, e.sc);
      chk("freeze_cnt_ls3", zc_b, e.zc);
      chk("flush_cnt_ls3", fc_b, e.fc);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 5, 5, 0, 1, 0, 0, 0, 0);
    idle(2);
    // Load-use on Rn; hazard present for one cycle only
    drive(1, 1, 5, 5, 0, 1, 0, 0, 0, 0);
    idle(5);
    // XZR destination, then matching Rm that is not read
    drive(1, 1, 31, 31, 0, 1, 0, 0, 0, 0);
    drive(1, 1, 7, 0, 7, 0, 0, 0, 0, 0);
    idle(2);
    // Branch during the second stall cycle
    drive(1, 1, 9, 0, 9, 0, 1, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    idle(3);
    // Freeze holds a pending branch for four cycles
    for (int i = 0; i < 4; i++) drive(1, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    idle(3);
    // Reset asserted mid-stall, between clock edges
    drive(1, 1, 3, 3, 0, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(3);
    // Clear coincident with a stall increment
    drive(1, 1, 4, 0, 4, 0, 1, 0, 0, 0);
    drive(1, 1, 4, 0, 4, 0, 1, 0, 0, 1);
    idle(4);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(2);
    for (int i = 0; i < 2000; i++) begin
      drive(($urandom_range(0, 99) != 0),
            ($urandom_range(0, 99) < 40),
            5'($urandom_range(28, 31)),
            5'($urandom_range(28, 31)),
            5'($urandom_range(28, 31)),
            1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 99) < 8),
            ($urandom_range(0, 99) < 10),
            ($urandom_range(0, 99) < 3));
    end
    idle(2);
    @(posedge clock);
    @(posedge clock);
    #1;
    chk("queue_drained", CW'(q_a.size() + q_b.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
